sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
- ADDR_W, 25, SDRAM controller address width.
- DATA_W, 16, data width.
- MAX_BURST, 32, accepted transactions per grant before a forced yield when the other master waits.
- MAX_PENDING, 7, maximum outstanding reads.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- iCLK  in  1  SDRAM controller clock; one clock.
- iRST  in  1  asynchronous, active-high reset.
- iRD_REQ  in  1  reader read request.
- iRD_ADDR  in  ADDR_W  reader address.
- oRD_WAIT  out  1  reader waitrequest.
- oRD_DATA  out  DATA_W  read data.
- oRD_DATAVALID  out  1  read data valid.
- iWR_REQ  in  1  writer write request.
- iWR_ADDR  in  ADDR_W  writer address.
- iWR_DATA  in  DATA_W  writer data.
- oWR_WAIT  out  1  writer waitrequest.
- oSLV_ADDR  out  ADDR_W  controller address.
- oSLV_READ  out  1  controller read, active high.
- oSLV_WRITE  out  1  controller write, active high.
- oSLV_WRDATA  out  DATA_W  controller write data.
- iSLV_WAIT  in  1  controller waitrequest.
- iSLV_RDDATA  in  DATA_W  controller read data.
- iSLV_RDVALID  in  1  controller readdatavalid.
- oGRANT  out  2  current state: 00 IDLE, 01 RD, 10 WR.
- oERROR  out  1  sticky protocol error.

Function
REQ-003 The state machine SHALL have states IDLE, RD and WR, and state SHALL change only on an iCLK rising edge.
REQ-004 In IDLE with a single requester, the next state SHALL be that requester's state; WR SHALL additionally require pending==0.
REQ-005 In IDLE with both requesting, the master not granted last SHALL win, and the last-granted flag SHALL reset to WR so the reader wins first.
REQ-006 In RD, oSLV_READ SHALL equal iRD_REQ && pending<MAX_PENDING, and oSLV_ADDR SHALL equal iRD_ADDR.
REQ-007 In RD, oRD_WAIT SHALL equal iSLV_WAIT || pending==MAX_PENDING.
REQ-008 In WR, oSLV_WRITE SHALL equal iWR_REQ, oSLV_ADDR SHALL equal iWR_ADDR, oSLV_WRDATA SHALL equal iWR_DATA, and oWR_WAIT SHALL equal iSLV_WAIT.
REQ-009 A non-granted master's waitrequest SHALL be 1; in IDLE both waitrequests SHALL be 1, oSLV_READ and oSLV_WRITE SHALL be 0, and oSLV_ADDR SHALL be 0.
REQ-010 An accepted transaction is a slave request with iSLV_WAIT=0; each SHALL increment burst_cnt, which SHALL saturate at MAX_BURST and clear on entry to IDLE.
REQ-011 RD or WR SHALL return to IDLE when its master's request is low.
REQ-012 RD or WR SHALL also return to IDLE when burst_cnt==MAX_BURST and the other master is requesting; no transaction SHALL be accepted on the exit cycle, with the slave request forced to 0 and waitrequest to 1.
REQ-013 The pending counter SHALL increment on an accepted read and decrement on iSLV_RDVALID; both in one cycle SHALL leave it unchanged.
REQ-014 oRD_DATA SHALL equal iSLV_RDDATA and oRD_DATAVALID SHALL equal iSLV_RDVALID in every state, including WR and IDLE, with zero latency.
REQ-015 A write request while pending>0 SHALL be held in IDLE until pending==0; reads SHALL be allowed to drain during this time.
REQ-016 oERROR SHALL set on iSLV_RDVALID with pending==0 (the counter SHALL stay 0) or on an accepted write while pending>0, and SHALL clear only on reset.
REQ-017 Grant switch latency SHALL be 2 cycles: one to IDLE and one to the new state.

Reset
REQ-018 When iRST=1, the block SHALL asynchronously set state=IDLE, pending=0, burst_cnt=0, last-granted=WR, oRD_WAIT=1, oWR_WAIT=1, oSLV_READ=0, oSLV_WRITE=0, oSLV_ADDR=0, oSLV_WRDATA=0, oGRANT=00 and oERROR=0.
REQ-019 On reset mid-transaction, in-flight read data SHALL still be forwarded on oRD_DATAVALID but SHALL NOT be counted or flagged.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Simultaneous requests after reset -> RD granted first; after reader drops, WR granted 2 cycles later.
- Reader requesting continuously with writer requesting, iSLV_WAIT=0 -> exactly 32 reads accepted, then IDLE, then WR.
- 7 reads accepted with no data returned -> oRD_WAIT=1 and oSLV_READ=0; one iSLV_RDVALID -> one more read accepted.
- Writer requests with pending=3 -> WR not granted until the 3rd iSLV_RDVALID; the grant then follows on the next cycle.
- iSLV_RDVALID with pending=0 -> oERROR=1 and stays 1 until iRST.
- iRST asserted in WR with iSLV_WAIT=1 -> outputs take REQ-018 values in the same cycle, asynchronously.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-master (reader/writer) arbiter onto one SDRAM controller port; zero-latency pass-through once granted, 2-cycle grant switch via IDLE.
// Backpressure: controller waitrequest passes to the granted master; the other master, and a reader at MAX_PENDING outstanding reads, see wait=1.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int MAX_BURST   = 32,
  parameter int MAX_PENDING = 7
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iRD_REQ,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic              oRD_WAIT,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oRD_DATAVALID,
  input  logic              iWR_REQ,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  output logic              oWR_WAIT,
  output logic [ADDR_W-1:0] oSLV_ADDR,
  output logic              oSLV_READ,
  output logic              oSLV_WRITE,
  output logic [DATA_W-1:0] oSLV_WRDATA,
  input  logic              iSLV_WAIT,
  input  logic [DATA_W-1:0] iSLV_RDDATA,
  input  logic              iSLV_RDVALID,
  output logic [1:0]        oGRANT,
  output logic              oERROR
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE = 2'b00, RD = 2'b01, WR = 2'b10} state_t;

  state_t        state_q, state_d;
  logic          last_wr_q, last_wr_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          error_q, error_d;
  logic          force_exit, rd_acc, wr_acc;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      pending_q <= '0;
      burst_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      pending_q <= pending_d;
      burst_q   <= burst_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    pending_d   = pending_q;
    burst_d     = burst_q;
    error_d     = error_q;
    oRD_WAIT    = 1'b1;
    oWR_WAIT    = 1'b1;
    oSLV_READ   = 1'b0;
    oSLV_WRITE  = 1'b0;
    oSLV_ADDR   = '0;
    oSLV_WRDATA = '0;
    // A full burst yields only when the other master is actually waiting.
    force_exit  = (burst_q == BURST_MAX) &&
                  (((state_q == RD) && iWR_REQ) || ((state_q == WR) && iRD_REQ));

    case (state_q)
      IDLE: begin
        // Reader wins ties unless it held the bus last; a write waits for reads to drain.
        if (iRD_REQ && (!iWR_REQ || last_wr_q)) begin
          state_d   = RD;
          last_wr_d = 1'b0;
        end else if (iWR_REQ && (pending_q == '0)) begin
          state_d   = WR;
          last_wr_d = 1'b1;
        end
      end
      RD: begin
        oSLV_ADDR = iRD_ADDR;
        if (force_exit || !iRD_REQ) state_d = IDLE;
        if (!force_exit) begin
          oSLV_READ = iRD_REQ && (pending_q != PEND_MAX);
          oRD_WAIT  = iSLV_WAIT || (pending_q == PEND_MAX);
        end
      end
      WR: begin
        oSLV_ADDR   = iWR_ADDR;
        oSLV_WRDATA = iWR_DATA;
        if (force_exit || !iWR_REQ) state_d = IDLE;
        if (!force_exit) begin
          oSLV_WRITE = iWR_REQ;
          oWR_WAIT   = iSLV_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_acc = oSLV_READ && !iSLV_WAIT;
    wr_acc = oSLV_WRITE && !iSLV_WAIT;

    // Stray read data never drives the counter below zero.
    if (rd_acc && !iSLV_RDVALID) begin
      pending_d = pending_q + 1'b1;
    end else if (!rd_acc && iSLV_RDVALID && (pending_q != '0)) begin
      pending_d = pending_q - 1'b1;
    end

    if ((iSLV_RDVALID && (pending_q == '0)) || (wr_acc && (pending_q != '0))) error_d = 1'b1;

    if (state_d == IDLE) begin
      burst_d = '0;
    end else if ((rd_acc || wr_acc) && (burst_q != BURST_MAX)) begin
      burst_d = burst_q + 1'b1;
    end
  end

  assign oGRANT        = state_q;
  assign oERROR        = error_q;
  assign oRD_DATA      = iSLV_RDDATA;
  assign oRD_DATAVALID = iSLV_RDVALID;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 25, DATA_W = 16, MAX_BURST = 32, MAX_PENDING = 7;

  logic              iCLK = 1'b0;
  logic              iRST;
  logic              iRD_REQ, iWR_REQ, iSLV_WAIT, iSLV_RDVALID;
  logic [ADDR_W-1:0] iRD_ADDR, iWR_ADDR;
  logic [DATA_W-1:0] iWR_DATA, iSLV_RDDATA;
  logic              oRD_WAIT, oRD_DATAVALID, oWR_WAIT, oSLV_READ, oSLV_WRITE, oERROR;
  logic [DATA_W-1:0] oRD_DATA, oSLV_WRDATA;
  logic [ADDR_W-1:0] oSLV_ADDR;
  logic [1:0]        oGRANT;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: 0 = nobody owns the port, 1 = reader, 2 = writer.
  int   m_owner, m_pend, m_burst;
  bit   m_last_wr, m_err;
  logic e_rd_wait, e_wr_wait, e_read, e_write;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wrdata;

  always #5 iCLK = ~iCLK;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .MAX_PENDING(MAX_PENDING)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iRD_REQ(iRD_REQ), .iRD_ADDR(iRD_ADDR), .oRD_WAIT(oRD_WAIT), .oRD_DATA(oRD_DATA), .oRD_DATAVALID(oRD_DATAVALID),
    .iWR_REQ(iWR_REQ), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA), .oWR_WAIT(oWR_WAIT),
    .oSLV_ADDR(oSLV_ADDR), .oSLV_READ(oSLV_READ), .oSLV_WRITE(oSLV_WRITE), .oSLV_WRDATA(oSLV_WRDATA),
    .iSLV_WAIT(iSLV_WAIT), .iSLV_RDDATA(iSLV_RDDATA), .iSLV_RDVALID(iSLV_RDVALID),
    .oGRANT(oGRANT), .oERROR(oERROR));

  task automatic model_reset();
    m_owner = 0; m_pend = 0; m_burst = 0; m_last_wr = 1; m_err = 0;
  endtask

  task automatic model_eval();
    bit yield;
    e_rd_wait = 1; e_wr_wait = 1; e_read = 0; e_write = 0; e_addr = '0; e_wrdata = '0;
    yield = (m_burst == MAX_BURST) && ((m_owner == 1 && iWR_REQ) || (m_owner == 2 && iRD_REQ));
    if (m_owner == 1) begin
      e_addr = iRD_ADDR;
      if (!yield) begin
        e_read    = iRD_REQ && (m_pend < MAX_PENDING);
        e_rd_wait = iSLV_WAIT || (m_pend == MAX_PENDING);
      end
    end else if (m_owner == 2) begin
      e_addr = iWR_ADDR;
      e_wrdata = iWR_DATA;
      if (!yield) begin
        e_write   = iWR_REQ;
        e_wr_wait = iSLV_WAIT;
      end
    end
  endtask

  task automatic model_advance();
    bit acc_rd, acc_wr, yield;
    int nxt;
    model_eval();
    acc_rd = e_read && !iSLV_WAIT;
    acc_wr = e_write && !iSLV_WAIT;
    yield  = (m_burst == MAX_BURST) && ((m_owner == 1 && iWR_REQ) || (m_owner == 2 && iRD_REQ));
    if ((iSLV_RDVALID && m_pend == 0) || (acc_wr && m_pend > 0)) m_err = 1;
    nxt = m_owner;
    if (m_owner == 0) begin
      if (iRD_REQ && iWR_REQ) begin
        if (m_last_wr) nxt = 1;
        else if (m_pend == 0) nxt = 2;
      end else if (iRD_REQ) nxt = 1;
      else if (iWR_REQ && m_pend == 0) nxt = 2;
      if (nxt == 1) m_last_wr = 0;
      if (nxt == 2) m_last_wr = 1;
    end else if (m_owner == 1) begin
      if (!iRD_REQ || yield) nxt = 0;
    end else begin
      if (!iWR_REQ || yield) nxt = 0;
    end
    if (acc_rd && !iSLV_RDVALID) m_pend = m_pend + 1;
    else if (!acc_rd && iSLV_RDVALID && m_pend > 0) m_pend = m_pend - 1;
    if (nxt == 0) m_burst = 0;
    else if (acc_rd || acc_wr) m_burst = (m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1;
    m_owner = nxt;
  endtask

  task automatic clk_step();
    model_advance();
    @(posedge iCLK);
    #2;
  endtask

  task automatic do_reset();
    iRST = 1; iRD_REQ = 0; iWR_REQ = 0; iSLV_WAIT = 0; iSLV_RDVALID = 0;
    iRD_ADDR = '0; iWR_ADDR = '0; iWR_DATA = '0; iSLV_RDDATA = '0;
    model_reset();
    @(posedge iCLK);
    #2;
    iRST = 0;
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (oGRANT !== 2'b00) begin n_bad++; $display("FAIL rst_grant: got %b want 00", oGRANT); end
    n_vec++; if (oRD_WAIT !== 1'b1) begin n_bad++; $display("FAIL rst_rd_wait: got %b want 1", oRD_WAIT); end
    n_vec++; if (oWR_WAIT !== 1'b1) begin n_bad++; $display("FAIL rst_wr_wait: got %b want 1", oWR_WAIT); end
    n_vec++; if ({oSLV_READ, oSLV_WRITE} !== 2'b00) begin n_bad++; $display("FAIL rst_rw: got %b want 00", {oSLV_READ, oSLV_WRITE}); end
    n_vec++; if (oSLV_ADDR !== '0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", oSLV_ADDR); end
    n_vec++; if (oSLV_WRDATA !== '0) begin n_bad++; $display("FAIL rst_wrdata: got %h want 0", oSLV_WRDATA); end
    n_vec++; if (oERROR !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", oERROR); end
    do_reset();
  endtask

  task automatic test_simultaneous();
    do_reset();
    iRD_REQ = 1; iWR_REQ = 1; iRD_ADDR = 25'h1ABCDE;
    #1;
    n_vec++; if (oGRANT !== 2'b00) begin n_bad++; $display("FAIL sim_idle: got %b want 00", oGRANT); end
    clk_step();
    n_vec++; if (oGRANT !== 2'b01) begin n_bad++; $display("FAIL sim_rd_first: got %b want 01", oGRANT); end
    n_vec++; if (oSLV_ADDR !== 25'h1ABCDE || oSLV_READ !== 1'b1) begin n_bad++; $display("FAIL sim_rd_drive: got %h/%b want 1abcde/1", oSLV_ADDR, oSLV_READ); end
    n_vec++; if (oWR_WAIT !== 1'b1) begin n_bad++; $display("FAIL sim_wr_blocked: got %b want 1", oWR_WAIT); end
    iRD_REQ = 0;
    clk_step();
    n_vec++; if (oGRANT !== 2'b00) begin n_bad++; $display("FAIL sim_switch_idle: got %b want 00", oGRANT); end
    clk_step();
    n_vec++; if (oGRANT !== 2'b10 || oSLV_WRITE !== 1'b1) begin n_bad++; $display("FAIL sim_wr_grant: got %b/%b want 10/1", oGRANT, oSLV_WRITE); end
    iWR_REQ = 0;
    clk_step();
  endtask

  task automatic test_burst_yield();
    int acc_n;
    bit acc, exit_seen;
    do_reset();
    iRD_REQ = 1; iWR_REQ = 1;
    clk_step();
    acc_n = 0; exit_seen = 0;
    for (int c = 0; c < 80 && !exit_seen; c++) begin
      #1;
      acc = (oGRANT == 2'b01) && oSLV_READ && !iSLV_WAIT;
      if (acc_n == MAX_BURST) begin
        exit_seen = 1;
        n_vec++; if ({oGRANT, oSLV_READ, oRD_WAIT} !== 4'b0101) begin n_bad++; $display("FAIL burst_exit_cycle: got %b want 0101", {oGRANT, oSLV_READ, oRD_WAIT}); end
      end
      if (acc) acc_n++;
      iRD_ADDR = ADDR_W'($urandom);
      iSLV_RDDATA = DATA_W'($urandom);
      clk_step();
      iSLV_RDVALID = acc;
    end
    n_vec++; if (acc_n != MAX_BURST || !exit_seen) begin n_bad++; $display("FAIL burst_count: got %0d reads want %0d", acc_n, MAX_BURST); end
    #1;
    n_vec++; if (oGRANT !== 2'b00) begin n_bad++; $display("FAIL burst_idle: got %b want 00", oGRANT); end
    clk_step();
    n_vec++; if (oGRANT !== 2'b10) begin n_bad++; $display("FAIL burst_wr_next: got %b want 10", oGRANT); end
    iRD_REQ = 0; iWR_REQ = 0;
    clk_step();
  endtask

  task automatic test_pending_limit();
    do_reset();
    iRD_REQ = 1;
    clk_step();
    repeat (MAX_PENDING) clk_step();
    n_vec++; if ({oRD_WAIT, oSLV_READ} !== 2'b10) begin n_bad++; $display("FAIL pend_full: got %b want 10", {oRD_WAIT, oSLV_READ}); end
    clk_step();
    n_vec++; if ({oRD_WAIT, oSLV_READ} !== 2'b10) begin n_bad++; $display("FAIL pend_hold: got %b want 10", {oRD_WAIT, oSLV_READ}); end
    iSLV_RDVALID = 1;
    clk_step();
    iSLV_RDVALID = 0;
    #1;
    n_vec++; if ({oRD_WAIT, oSLV_READ} !== 2'b01) begin n_bad++; $display("FAIL pend_reopen: got %b want 01", {oRD_WAIT, oSLV_READ}); end
    clk_step();
    n_vec++; if ({oRD_WAIT, oSLV_READ, oERROR} !== 3'b100) begin n_bad++; $display("FAIL pend_refull: got %b want 100", {oRD_WAIT, oSLV_READ, oERROR}); end
    iRD_REQ = 0;
    clk_step();
  endtask

  task automatic test_write_hold();
    do_reset();
    iRD_REQ = 1;
    clk_step();
    repeat (3) clk_step();
    iRD_REQ = 0; iWR_REQ = 1;
    clk_step();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if ({oGRANT, oWR_WAIT} !== 3'b001) begin n_bad++; $display("FAIL hold_idle_%0d: got %b want 001", k, {oGRANT, oWR_WAIT}); end
      iSLV_RDVALID = 1; iSLV_RDDATA = DATA_W'($urandom);
      #1;
      n_vec++; if (oRD_DATAVALID !== 1'b1 || oRD_DATA !== iSLV_RDDATA) begin n_bad++; $display("FAIL hold_fwd_%0d: got %b/%h want 1/%h", k, oRD_DATAVALID, oRD_DATA, iSLV_RDDATA); end
      clk_step();
      iSLV_RDVALID = 0;
    end
    #1;
    n_vec++; if (oGRANT !== 2'b00) begin n_bad++; $display("FAIL hold_last_idle: got %b want 00", oGRANT); end
    clk_step();
    n_vec++; if ({oGRANT, oERROR} !== 3'b100) begin n_bad++; $display("FAIL hold_wr_grant: got %b want 100", {oGRANT, oERROR}); end
    iWR_REQ = 0;
    clk_step();
  endtask

  task automatic test_error_sticky();
    do_reset();
    iSLV_RDVALID = 1;
    #1;
    n_vec++; if (oERROR !== 1'b0) begin n_bad++; $display("FAIL err_not_yet: got %b want 0", oERROR); end
    clk_step();
    iSLV_RDVALID = 0;
    n_vec++; if (oERROR !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", oERROR); end
    iRD_REQ = 1;
    repeat (5) clk_step();
    n_vec++; if (oERROR !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", oERROR); end
    do_reset();
    n_vec++; if (oERROR !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", oERROR); end
  endtask

  task automatic test_async_reset();
    do_reset();
    iWR_REQ = 1; iSLV_WAIT = 1; iWR_ADDR = ADDR_W'($urandom); iWR_DATA = DATA_W'($urandom);
    clk_step();
    n_vec++; if ({oGRANT, oSLV_WRITE, oWR_WAIT} !== 4'b1011 || oSLV_WRDATA !== iWR_DATA || oSLV_ADDR !== iWR_ADDR)
      begin n_bad++; $display("FAIL ar_in_wr: got %b %h %h", {oGRANT, oSLV_WRITE, oWR_WAIT}, oSLV_ADDR, oSLV_WRDATA); end
    iRST = 1; iSLV_RDVALID = 1; iSLV_RDDATA = 16'hBEEF;
    model_reset();
    #1;
    n_vec++; if ({oGRANT, oRD_WAIT, oWR_WAIT, oSLV_READ, oSLV_WRITE, oERROR} !== 7'b0011000 || oSLV_ADDR !== '0 || oSLV_WRDATA !== '0)
      begin n_bad++; $display("FAIL ar_outputs: got %b %h %h", {oGRANT, oRD_WAIT, oWR_WAIT, oSLV_READ, oSLV_WRITE, oERROR}, oSLV_ADDR, oSLV_WRDATA); end
    n_vec++; if (oRD_DATAVALID !== 1'b1 || oRD_DATA !== 16'hBEEF) begin n_bad++; $display("FAIL ar_fwd: got %b/%h want 1/beef", oRD_DATAVALID, oRD_DATA); end
    @(posedge iCLK);
    #2;
    iRST = 0; iSLV_RDVALID = 0; iSLV_WAIT = 0;
    clk_step();
    n_vec++; if ({oGRANT, oERROR} !== 3'b100) begin n_bad++; $display("FAIL ar_after: got %b want 100", {oGRANT, oERROR}); end
    iWR_REQ = 0;
    clk_step();
  endtask

  task automatic test_random();
    logic [64:0] got, exp;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) iRD_REQ = ~iRD_REQ;
      if ($urandom_range(0, 11) == 0) iWR_REQ = ~iWR_REQ;
      iSLV_WAIT    = ($urandom_range(0, 3) == 0);
      iSLV_RDVALID = (m_pend > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 999) == 0);
      iRD_ADDR = ADDR_W'($urandom); iWR_ADDR = ADDR_W'($urandom);
      iWR_DATA = DATA_W'($urandom); iSLV_RDDATA = DATA_W'($urandom);
      #1;
      model_eval();
      got = {oGRANT, oRD_WAIT, oWR_WAIT, oSLV_READ, oSLV_WRITE, oSLV_ADDR, oSLV_WRDATA, oRD_DATA, oRD_DATAVALID, oERROR};
      exp = {2'(m_owner), e_rd_wait, e_wr_wait, e_read, e_write, e_addr, e_wrdata, iSLV_RDDATA, iSLV_RDVALID, m_err};
      n_vec++; if (got !== exp) begin n_bad++; $display("FAIL rand_cyc%0d: got %h want %h", c, got, exp); end
      clk_step();
    end
  endtask

  initial begin
    iRST = 1; iRD_REQ = 0; iWR_REQ = 0; iSLV_WAIT = 0; iSLV_RDVALID = 0;
    iRD_ADDR = '0; iWR_ADDR = '0; iWR_DATA = '0; iSLV_RDDATA = '0;
    model_reset();
    test_reset();
    test_simultaneous();
    test_burst_yield();
    test_pending_limit();
    test_write_hold();
    test_error_sticky();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
